// File: rtl/slinky_dram_ctrl.sv
// Apple II slot RAM-card controller: 6502 register window, auto-stepping
// pointer, DRAM RAS/CAS sequencing with CAS-before-RAS refresh.
module slinky_dram_ctrl #(
    parameter int ADDR_W     = 24,
    parameter int RA_W       = 11,
    parameter int BANKS      = 2,
    parameter int REF_PERIOD = 13
) (
    input  logic              C7M,
    input  logic              RES,
    input  logic              PHI1,
    input  logic [3:0]        A,
    input  logic              nWE,
    input  logic              nDEVSEL,
    input  logic              nIOSEL,
    input  logic [7:0]        D_in,
    output logic [7:0]        D_out,
    output logic              D_oe,
    input  logic [7:0]        RD_in,
    output logic [RA_W-1:0]   RA,
    output logic              nRAS,
    output logic [BANKS-1:0]  nCAS,
    output logic              nRWE,
    output logic [ADDR_W-1:0] Ptr
);

    localparam int BB = (BANKS == 4) ? 2 : ((BANKS == 2) ? 1 : 0);

    // Refresh sequencer: CAS from the S==1 edge, RAS from S==2, both off at S==3.
    typedef enum logic [1:0] {
        REF_IDLE,
        REF_CAS,
        REF_RAS
    } ref_state_t;

    ref_state_t ref_state, ref_next;

    logic [2:0]        s;
    logic              phi1r, phi0seen, regen, dben;
    logic [ADDR_W-1:0] ptr, ptr_step, ptr_wr;
    logic [1:0]        mode;
    logic [7:0]        refcnt;
    logic              refdue, pendstep;
    logic              rasq, casel, weq;
    logic [BANKS-1:0]  casq, bank_sel;
    logic              ramsel, regwr;
    logic [23:0]       ptr_ext, ptr_wr_ext;
    logic [7:0]        rdata;

    generate
        if (BB == 0) begin : g_one_bank
            assign bank_sel = 1'b1;
        end else begin : g_multi_bank
            assign bank_sel = BANKS'(1) << ptr[2*RA_W +: BB];
        end
    endgenerate

    assign ramsel   = ~nDEVSEL & regen & (A == 4'd3);
    assign regwr    = ~nDEVSEL & regen & ~nWE;
    assign ptr_step = mode[0] ? (ptr - ADDR_W'(1)) : (ptr + ADDR_W'(1));

    // Pointer bytes are handled on a 24-bit view so that bits >= ADDR_W read 0.
    always_comb begin
        ptr_ext = '0;
        ptr_ext[ADDR_W-1:0] = ptr;
        ptr_wr_ext = ptr_ext;
        case (A)
            4'd0:    ptr_wr_ext[7:0]   = D_in;
            4'd1:    ptr_wr_ext[15:8]  = D_in;
            4'd2:    ptr_wr_ext[23:16] = D_in;
            default: ptr_wr_ext = ptr_ext;
        endcase
        ptr_wr = ptr_wr_ext[ADDR_W-1:0];
    end

    always_comb begin
        rdata = '0;
        case (A)
            4'd0:    rdata = ptr_ext[7:0];
            4'd1:    rdata = ptr_ext[15:8];
            4'd2:    rdata = ptr_ext[23:16];
            4'd3:    rdata = RD_in;
            4'd4:    rdata = {6'b0, mode};
            4'd5:    rdata = {6'b0, pendstep, refdue};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        ref_next = ref_state;
        case (ref_state)
            REF_IDLE: if (s == 3'd1 && refdue) ref_next = REF_CAS;
            REF_CAS:  if (s == 3'd2) ref_next = REF_RAS;
            REF_RAS:  if (s == 3'd3) ref_next = REF_IDLE;
            default:  ref_next = REF_IDLE;
        endcase
    end

    always_ff @(posedge C7M) begin
        if (RES) ref_state <= REF_IDLE;
        else     ref_state <= ref_next;
    end

    always_ff @(posedge C7M) begin
        if (RES) begin
            s        <= 3'd0;
            phi1r    <= 1'b0;
            phi0seen <= 1'b0;
            regen    <= 1'b0;
            dben     <= 1'b0;
            ptr      <= '0;
            mode     <= 2'b00;
            refcnt   <= 8'(REF_PERIOD - 1);
            refdue   <= 1'b0;
            pendstep <= 1'b0;
            rasq     <= 1'b0;
            casel    <= 1'b0;
            casq     <= '0;
            weq      <= 1'b0;
        end else begin
            phi1r <= PHI1;
            if (!PHI1) phi0seen <= 1'b1;
            // S restarts on each PHI1 rise and saturates at 7 if PHI1 stalls.
            if (PHI1 && !phi1r && phi0seen) s <= 3'd1;
            else if (s != 3'd0 && s != 3'd7) s <= s + 3'd1;
            if (s == 3'd4 && !nIOSEL) regen <= 1'b1;
            dben <= s[2];
            case (s)
                3'd1: begin
                    rasq  <= 1'b0;
                    casel <= 1'b0;
                    casq  <= '0;
                    weq   <= 1'b0;
                    if (pendstep) begin
                        ptr      <= ptr_step;
                        pendstep <= 1'b0;
                    end
                end
                3'd3: begin
                    if (refcnt == 8'd0) begin
                        refcnt <= 8'(REF_PERIOD - 1);
                        refdue <= 1'b1;
                    end else begin
                        refcnt <= refcnt - 8'd1;
                        if (ref_state == REF_RAS) refdue <= 1'b0;
                    end
                end
                3'd4: if (ramsel && nWE) rasq <= 1'b1;
                3'd5: begin
                    if (ramsel && nWE) begin
                        casel <= 1'b1;
                        casq  <= casq | bank_sel;
                    end else if (ramsel && !nWE) begin
                        rasq <= 1'b1;
                    end
                end
                3'd6: begin
                    if (ramsel && !nWE) begin
                        casel <= 1'b1;
                        casq  <= casq | bank_sel;
                        weq   <= 1'b1;
                    end
                    if (ramsel && !mode[1]) pendstep <= 1'b1;
                    if (regwr && A <= 4'd2) ptr <= ptr_wr;
                    if (regwr && A == 4'd4) mode <= D_in[1:0];
                end
                default: ;
            endcase
        end
    end

    assign RA    = casel ? ptr[RA_W-1:0] : ptr[2*RA_W-1:RA_W];
    assign nRAS  = ~(rasq | (ref_state == REF_RAS));
    assign nCAS  = ~(casq | {BANKS{ref_state != REF_IDLE}});
    assign nRWE  = ~weq;
    assign D_oe  = dben & nWE & ~nDEVSEL & regen;
    assign D_out = D_oe ? rdata : 8'h00;
    assign Ptr   = ptr;

endmodule
